// File: rtl/pipe_stall_controller.sv
// pipe_stall_controller
//   Central sequencer for the 5-stage scalar/vector pipeline. Turns EX/MEM
//   completion handshakes and branch resolution into PC write-enable,
//   pipe-register enables, bubble inserts and flushes. Outputs are Mealy:
//   a stall freezes stages in the same cycle the condition appears.
//
//   Ports
//     CLK, RST            clock (rising edge), async active-low reset
//     ex_multi_i/ex_ready_i    multi-cycle EX op / EX done
//     mem_multi_i/mem_ready_i  multi-cycle MEM access / MEM done
//     branch_taken_i      branch resolved taken in EX
//     halt_i              end-of-program halt request
//     pc_we_o, en_*_o     PC and pipe-register enables
//     bubble_*_o          load zeroed controls into EX/MEM, MEM/WB
//     flush_o             clear IF/ID and ID/EX
//     mem_start_o         one-cycle start pulse to MEM
//     timeout_o           sticky stall-watchdog flag
//     state_o             RUN=0 EX_WAIT=1 MEM_WAIT=2 FLUSH=3 HALT=4
//     stall_cnt_o         consecutive stall cycles, saturating
//
//   Build option STALL_PERF_EN adds perf_ex_stall_o, perf_mem_stall_o and
//   perf_flush_o (32-bit wrapping cycle counters).
module pipe_stall_controller #(
  parameter int MAX_STALL    = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CW           = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ex_multi_i,
  input  logic          ex_ready_i,
  input  logic          mem_multi_i,
  input  logic          mem_ready_i,
  input  logic          branch_taken_i,
  input  logic          halt_i,
  output logic          pc_we_o,
  output logic          en_if_id_o,
  output logic          en_id_ex_o,
  output logic          en_ex_mem_o,
  output logic          en_mem_wb_o,
  output logic          bubble_ex_mem_o,
  output logic          bubble_mem_wb_o,
  output logic          flush_o,
  output logic          mem_start_o,
  output logic          timeout_o,
  output logic [2:0]    state_o,
  output logic [CW-1:0] stall_cnt_o
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]   perf_ex_stall_o,
  output logic [31:0]   perf_mem_stall_o,
  output logic [31:0]   perf_flush_o
`endif
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_EX_WAIT  = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_FLUSH    = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [31:0]   WD_LIM  = 32'(MAX_STALL - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  // Remaining FLUSH-state cycles after the branch cycle itself.
  localparam logic [1:0]    FL_INIT = 2'(FLUSH_CYCLES - 1);

  state_t        state, nxt;
  logic [1:0]    fcnt;
  logic [CW-1:0] cnt;
  logic          timeout_q, mm_q;

  logic mstall, xstall;
  // Decode classes: mem-stall, ex-stall, advance with branch handling,
  // advance without branch handling (MEM_WAIT exit), flush-state cycle.
  logic dec_ms, dec_xs, dec_go, dec_open, dec_fl;
  logic all_en, stalled, trip, fl_load, flush_act;

  assign mstall = mem_multi_i & ~mem_ready_i;
  assign xstall = ex_multi_i & ~ex_ready_i;

  always_comb begin
    dec_ms   = 1'b0;
    dec_xs   = 1'b0;
    dec_go   = 1'b0;
    dec_open = 1'b0;
    dec_fl   = 1'b0;
    fl_load  = 1'b0;
    nxt      = state;
    case (state)
      // EX_WAIT decodes like RUN: mem stall wins, ex stall holds, and
      // completion advances with the same branch handling as RUN.
      S_RUN, S_EX_WAIT: begin
        if (mstall) begin
          dec_ms = 1'b1;
          nxt    = S_MEM_WAIT;
        end else if (xstall) begin
          dec_xs = 1'b1;
          nxt    = S_EX_WAIT;
        end else begin
          dec_go = 1'b1;
          nxt    = S_RUN;
          if (branch_taken_i && FLUSH_CYCLES > 1) begin
            nxt     = S_FLUSH;
            fl_load = 1'b1;
          end
        end
      end
      S_MEM_WAIT: begin
        if (mstall) begin
          dec_ms = 1'b1;
        end else if (xstall) begin
          // MEM done but EX still busy: hand over to the EX stall directly
          dec_xs = 1'b1;
          nxt    = S_EX_WAIT;
        end else begin
          dec_open = 1'b1;
          nxt      = S_RUN;
        end
      end
      S_FLUSH: begin
        dec_fl = 1'b1;
        if (fcnt <= 2'd1) nxt = S_RUN;
      end
      S_HALT: ;
      default: nxt = S_RUN;
    endcase
    stalled = dec_ms | dec_xs;
    trip    = stalled && (32'(cnt) >= WD_LIM);
    if ((halt_i || trip) && state != S_HALT) nxt = S_HALT;
  end

  assign all_en    = dec_go | dec_open | dec_fl;
  assign flush_act = dec_fl | (dec_go & branch_taken_i);

  // Everything combinational is forced low while reset is held.
  assign pc_we_o         = RST & all_en;
  assign en_if_id_o      = RST & all_en;
  assign en_id_ex_o      = RST & all_en;
  assign en_ex_mem_o     = RST & (all_en | dec_xs);
  assign en_mem_wb_o     = RST & (all_en | dec_xs);
  assign bubble_ex_mem_o = RST & dec_xs;
  assign bubble_mem_wb_o = RST & dec_ms;
  assign flush_o         = RST & flush_act;
  assign mem_start_o     = RST & mem_multi_i & ~mm_q &
                           (state == S_RUN || state == S_EX_WAIT);
  assign timeout_o       = timeout_q;
  assign state_o         = state;
  assign stall_cnt_o     = cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_RUN;
      fcnt      <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
      mm_q      <= 1'b0;
    end else begin
      state <= nxt;
      mm_q  <= mem_multi_i;
      if (fl_load)                   fcnt <= FL_INIT;
      else if (dec_fl && fcnt != '0) fcnt <= fcnt - 2'd1;
      if (stalled) begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
      if (trip) timeout_q <= 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_ex, perf_mem, perf_fl;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_ex  <= '0;
      perf_mem <= '0;
      perf_fl  <= '0;
    end else begin
      if (dec_xs)    perf_ex  <= perf_ex + 32'd1;
      if (dec_ms)    perf_mem <= perf_mem + 32'd1;
      if (flush_act) perf_fl  <= perf_fl + 32'd1;
    end
  end

  assign perf_ex_stall_o  = perf_ex;
  assign perf_mem_stall_o = perf_mem;
  assign perf_flush_o     = perf_fl;
`endif

endmodule

// File: tb/tb_pipe_stall_controller.sv
module tb_pipe_stall_controller;
  localparam int MAX_STALL    = 64;
  localparam int FLUSH_CYCLES = 2;
  localparam int CW           = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic ex_multi_i = 0, ex_ready_i = 0, mem_multi_i = 0, mem_ready_i = 0;
  logic branch_taken_i = 0, halt_i = 0;
  logic pc_we_o, en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o;
  logic bubble_ex_mem_o, bubble_mem_wb_o, flush_o, mem_start_o, timeout_o;
  logic [2:0]    state_o;
  logic [CW-1:0] stall_cnt_o;

  pipe_stall_controller #(.MAX_STALL(MAX_STALL), .FLUSH_CYCLES(FLUSH_CYCLES), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ex_multi_i(ex_multi_i), .ex_ready_i(ex_ready_i),
    .mem_multi_i(mem_multi_i), .mem_ready_i(mem_ready_i),
    .branch_taken_i(branch_taken_i), .halt_i(halt_i),
    .pc_we_o(pc_we_o), .en_if_id_o(en_if_id_o), .en_id_ex_o(en_id_ex_o),
    .en_ex_mem_o(en_ex_mem_o), .en_mem_wb_o(en_mem_wb_o),
    .bubble_ex_mem_o(bubble_ex_mem_o), .bubble_mem_wb_o(bubble_mem_wb_o),
    .flush_o(flush_o), .mem_start_o(mem_start_o), .timeout_o(timeout_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  wire [4:0] en = {pc_we_o, en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o};

  task automatic set_in(input logic em, input logic er, input logic mm,
                        input logic mr, input logic br, input logic hl);
    ex_multi_i = em; ex_ready_i = er; mem_multi_i = mm;
    mem_ready_i = mr; branch_taken_i = br; halt_i = hl;
  endtask

  task automatic next_cyc;
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------- reset
  task automatic test_reset;
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (en !== 5'b00000) $display("FAIL rst_held_en got %b want 00000", en); else passes++;
    checks++; if (flush_o !== 1'b0) $display("FAIL rst_held_flush got %b want 0", flush_o); else passes++;
    next_cyc;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (state_o !== 3'd0) $display("FAIL rst_rel_state got %0d want 0", state_o); else passes++;
    checks++; if (en !== 5'b11111) $display("FAIL rst_rel_en got %b want 11111", en); else passes++;
    checks++; if (timeout_o !== 1'b0) $display("FAIL rst_rel_timeout got %b want 0", timeout_o); else passes++;
    checks++; if (stall_cnt_o !== 8'd0) $display("FAIL rst_rel_cnt got %0d want 0", stall_cnt_o); else passes++;
  endtask

  // -------------------------------------------------------- EX multi-cycle
  task automatic test_ex_stall;
    for (int i = 0; i < 6; i++) begin
      next_cyc;
      set_in(1, i == 5, 0, 0, 0, 0);
      @(negedge CLK);
      if (i < 5) begin
        checks++; if ({en, bubble_ex_mem_o} !== 6'b000111)
          $display("FAIL ex_stall_en cyc%0d got %b want 000111", i, {en, bubble_ex_mem_o}); else passes++;
        checks++; if (state_o !== ((i == 0) ? 3'd0 : 3'd1))
          $display("FAIL ex_stall_state cyc%0d got %0d want %0d", i, state_o, (i == 0) ? 0 : 1); else passes++;
      end else begin
        checks++; if ({en, bubble_ex_mem_o} !== 6'b111110)
          $display("FAIL ex_done_en got %b want 111110", {en, bubble_ex_mem_o}); else passes++;
      end
      checks++; if (stall_cnt_o !== CW'(i))
        $display("FAIL ex_stall_cnt cyc%0d got %0d want %0d", i, stall_cnt_o, i); else passes++;
    end
    next_cyc;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++; if (state_o !== 3'd0) $display("FAIL ex_after_state got %0d want 0", state_o); else passes++;
    checks++; if (stall_cnt_o !== 8'd0) $display("FAIL ex_after_cnt got %0d want 0", stall_cnt_o); else passes++;
  endtask

  // ------------------------------------------------ MEM then EX stall chain
  task automatic test_mem_ex;
    int starts = 0;
    logic [4:0] we;
    logic [2:0] ws;
    for (int i = 0; i < 8; i++) begin
      next_cyc;
      if (i < 7) set_in(1, i >= 6, 1, i >= 3, 0, 0);
      else       set_in(0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      if (mem_start_o === 1'b1) starts++;
      we = (i < 3) ? 5'b00000 : (i < 6) ? 5'b00011 : 5'b11111;
      ws = (i == 0) ? 3'd0 : (i < 4) ? 3'd2 : (i < 7) ? 3'd1 : 3'd0;
      checks++; if (en !== we) $display("FAIL memex_en cyc%0d got %b want %b", i, en, we); else passes++;
      checks++; if (state_o !== ws) $display("FAIL memex_state cyc%0d got %0d want %0d", i, state_o, ws); else passes++;
      if (i < 3) begin
        checks++; if (bubble_mem_wb_o !== 1'b1)
          $display("FAIL memex_bubble_mw cyc%0d got %b want 1", i, bubble_mem_wb_o); else passes++;
      end
    end
    checks++; if (starts != 1) $display("FAIL mem_start_count got %0d want 1", starts); else passes++;
  endtask

  // ------------------------------------------------------------ branch flush
  task automatic test_branch;
    int flushes = 0;
    for (int i = 0; i < 4; i++) begin
      next_cyc;
      set_in(0, 0, 0, 0, i < 2, 0);
      @(negedge CLK);
      if (flush_o === 1'b1) flushes++;
      checks++; if ({flush_o, en} !== {(i < 2) ? 1'b1 : 1'b0, 5'b11111})
        $display("FAIL branch_flush_en cyc%0d got %b want %b", i, {flush_o, en}, {(i < 2), 5'b11111}); else passes++;
      if (i == 1) begin
        checks++; if (state_o !== 3'd3) $display("FAIL branch_state got %0d want 3", state_o); else passes++;
      end
    end
    checks++; if (flushes != FLUSH_CYCLES)
      $display("FAIL branch_flush_len got %0d want %0d", flushes, FLUSH_CYCLES); else passes++;
  endtask

  // -------------------------------------------------------------- halt_i
  task automatic test_halt;
    next_cyc;
    set_in(0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    checks++; if ({state_o, en} !== {3'd0, 5'b11111})
      $display("FAIL halt_req_cycle got %b want %b", {state_o, en}, {3'd0, 5'b11111}); else passes++;
    next_cyc;
    set_in(1, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checks++; if ({state_o, en, bubble_ex_mem_o, bubble_mem_wb_o, flush_o} !== {3'd4, 8'd0})
      $display("FAIL halt_state got %b want %b", {state_o, en, bubble_ex_mem_o, bubble_mem_wb_o, flush_o}, {3'd4, 8'd0});
    else passes++;
    next_cyc;
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    next_cyc;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if ({state_o, en} !== {3'd0, 5'b11111})
      $display("FAIL halt_exit got %b want %b", {state_o, en}, {3'd0, 5'b11111}); else passes++;
  endtask

  // ------------------------------------------------------------ watchdog
  task automatic test_watchdog;
    for (int i = 0; i <= MAX_STALL; i++) begin
      next_cyc;
      set_in(1, 0, 0, 0, 0, 0);
      @(negedge CLK);
      if (i == MAX_STALL - 1) begin
        checks++; if ({timeout_o, en} !== 6'b000011)
          $display("FAIL wd_last_stall got %b want 000011", {timeout_o, en}); else passes++;
        checks++; if (stall_cnt_o !== CW'(MAX_STALL - 1))
          $display("FAIL wd_cnt got %0d want %0d", stall_cnt_o, MAX_STALL - 1); else passes++;
      end
      if (i == MAX_STALL) begin
        checks++; if ({timeout_o, state_o, en} !== {1'b1, 3'd4, 5'b00000})
          $display("FAIL wd_trip got %b want %b", {timeout_o, state_o, en}, {1'b1, 3'd4, 5'b00000}); else passes++;
      end
    end
    // async reset between clock edges
    #2 RST = 1'b0;
    #1;
    checks++; if ({timeout_o, state_o, en, stall_cnt_o} !== {1'b0, 3'd0, 5'b00000, 8'd0})
      $display("FAIL wd_async_rst got %b want 0", {timeout_o, state_o, en, stall_cnt_o}); else passes++;
    next_cyc;
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++; if ({timeout_o, state_o, en} !== {1'b0, 3'd0, 5'b11111})
      $display("FAIL wd_recover got %b want %b", {timeout_o, state_o, en}, {1'b0, 3'd0, 5'b11111}); else passes++;
  endtask

  // --------------------------------------------------- reference model
  // Each cycle is classified by what the pipeline does; expected outputs
  // follow from the class, and the next mode from the class and inputs.
  localparam int C_MS = 0, C_XS = 1, C_GO = 2, C_OPEN = 3, C_FL = 4, C_HALT = 5;
  int m_mode, m_fdone, m_run;
  bit m_to, m_prevmm;

  function automatic int m_class(input int mode, input bit em, input bit er,
                                 input bit mm, input bit mr);
    if (mode == 4) return C_HALT;
    if (mode == 3) return C_FL;
    if (mm && !mr) return C_MS;
    if (em && !er) return C_XS;
    return (mode == 2) ? C_OPEN : C_GO;
  endfunction

  task automatic m_reset;
    m_mode = 0; m_fdone = 0; m_run = 0; m_to = 0; m_prevmm = 0;
  endtask

  task automatic test_random;
    int hold = 0;
    int halted = 0;
    int cls;
    int nm;
    bit stl, trp;
    logic [8:0] got_f, exp_f;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      next_cyc;
      RST = !((halted >= 2) || ($urandom % 400 == 0));
      if (hold == 0 && $urandom % 250 == 0) hold = 70;
      if (hold > 0) begin
        hold--;
        set_in(1, 0, $urandom % 5 == 0, $urandom % 2, $urandom % 6 == 0, 0);
      end else begin
        set_in($urandom % 3 == 0, $urandom % 3 == 0, $urandom % 4 == 0,
               $urandom % 3 == 0, $urandom % 6 == 0, $urandom % 150 == 0);
      end
      if (!RST) begin m_reset(); halted = 0; end
      @(negedge CLK);
      cls = m_class(m_mode, ex_multi_i, ex_ready_i, mem_multi_i, mem_ready_i);
      if (!RST) exp_f = '0;
      else begin
        exp_f[8:4] = (cls == C_GO || cls == C_OPEN || cls == C_FL) ? 5'b11111 :
                     (cls == C_XS) ? 5'b00011 : 5'b00000;
        exp_f[3] = (cls == C_XS);
        exp_f[2] = (cls == C_MS);
        exp_f[1] = (cls == C_FL) || (cls == C_GO && branch_taken_i);
        exp_f[0] = mem_multi_i && !m_prevmm && (m_mode == 0 || m_mode == 1);
      end
      got_f = {en, bubble_ex_mem_o, bubble_mem_wb_o, flush_o, mem_start_o};
      checks++; if (got_f !== exp_f)
        $display("FAIL rnd_outputs n%0d got %b want %b", n, got_f, exp_f); else passes++;
      checks++; if ({timeout_o, state_o} !== {m_to, 3'(m_mode)})
        $display("FAIL rnd_state n%0d got %b want %b", n, {timeout_o, state_o}, {m_to, 3'(m_mode)}); else passes++;
      checks++; if (stall_cnt_o !== CW'(m_run))
        $display("FAIL rnd_cnt n%0d got %0d want %0d", n, stall_cnt_o, m_run); else passes++;
      if (RST) begin
        stl = (cls == C_MS || cls == C_XS);
        trp = stl && (m_run >= MAX_STALL - 1);
        case (cls)
          C_MS: nm = 2;
          C_XS: nm = 1;
          C_GO: begin
            nm = 0;
            if (branch_taken_i && FLUSH_CYCLES > 1) begin nm = 3; m_fdone = 1; end
          end
          C_OPEN: nm = 0;
          C_FL: begin
            m_fdone++;
            nm = (m_fdone >= FLUSH_CYCLES) ? 0 : 3;
          end
          default: nm = 4;
        endcase
        if ((halt_i || trp) && m_mode != 4) nm = 4;
        if (trp) m_to = 1;
        m_run = stl ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        m_prevmm = mem_multi_i;
        m_mode = nm;
        halted = (m_mode == 4) ? halted + 1 : 0;
      end
    end
    next_cyc;
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ex_stall();
    test_mem_ex();
    test_branch();
    test_halt();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
